// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit holding the architectural
// HI/LO registers. Runs MULT/MULTU as 32 shift-add steps and DIV/DIVU as
// 32 restoring shift-subtract steps. Signed operations run on operand
// magnitudes, and the sign is fixed up in a final FIX cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// RUN   | one multiply or divide iteration per clock, counter 0..ITER-1
// FIX   | sign correction; hi/lo are written on the edge that leaves FIX
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request strobe, ignored while busy
//   op    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//           11x NOP
//   opA   - rs value: multiplicand, dividend or MTHI/MTLO data
//   opB   - rt value: multiplier or divisor
//   hi/lo - architectural HI/LO registers
//   busy  - registered decode of state != IDLE
//   done  - one-cycle pulse after hi/lo are committed by a mult/div

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res;    // product or quotient must be negated
    logic             neg_rem;    // remainder must be negated (dividend < 0)
    logic             div_zero;
    logic [WIDTH-1:0] a_raw;      // original dividend, returned as HI on divide-by-zero
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_hi;     // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits then quotient

    // Operand decode for the start edge. The magnitude of the most negative
    // value is correctly 2^(WIDTH-1) when it is read as unsigned.
    logic             signed_op;
    logic             is_muldiv;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;

    assign signed_op = ~op[0];
    assign is_muldiv = ~op[2];
    assign a_mag_in  = (signed_op && opA[WIDTH-1]) ? (~opA + 1'b1) : opA;
    assign b_mag_in  = (signed_op && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;

    // Multiply step: add the multiplicand when the LSB of the multiplier is
    // set, then shift the 2*WIDTH+1 bit {carry, acc_hi, acc_lo} right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});

    // Divide step: shift the next dividend bit into the partial remainder.
    // That shifted value needs WIDTH+1 bits. Subtract only if it fits.
    // When the subtraction is taken, the result is below the divisor, so
    // WIDTH bits are enough for it.
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, b_mag});
    assign div_diff  = div_shift[WIDTH-1:0] - b_mag;

    // Sign correction applied during FIX.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = ~prod + 1'b1;

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div) begin
            fix_hi = neg_res ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi;
            fix_lo = neg_res ? prod_neg[WIDTH-1:0]       : acc_lo;
        end else if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = {WIDTH{1'b1}};
        end else begin
            fix_hi = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
            fix_lo = neg_res ? (~acc_lo + 1'b1) : acc_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_muldiv) begin
                            is_div   <= op[1];
                            neg_res  <= signed_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                            neg_rem  <= signed_op & opA[WIDTH-1];
                            div_zero <= (opB == '0);
                            a_raw    <= opA;
                            a_mag    <= a_mag_in;
                            b_mag    <= b_mag_in;
                            acc_hi   <= '0;
                            acc_lo   <= op[1] ? a_mag_in : b_mag_in;
                            cnt      <= '0;
                            state    <= S_RUN;
                            busy     <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            hi <= opA;
                        end else if (op == OP_MTLO) begin
                            lo <= opA;
                        end
                    end
                end

                S_RUN: begin
                    if (is_div) begin
                        acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against a
// plain-arithmetic model of HI/LO (64-bit products, truncating division).

module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO after a mult/div, from plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (o)
            3'd0: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_hi = sr[31:0];
                    m_lo = sq[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                end
            end
        endcase
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] d);
        start = 1'b1;
        op    = to_hi ? 3'd4 : 3'd5;
        opA   = d;
        tick();
        start = 1'b0;
        if (to_hi) m_hi = d;
        else       m_lo = d;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        check("mt_busy", 32'(busy), 32'd0);
    endtask

    // Issue one mult/div. Optionally poke a second start mid-run, then
    // check busy length, done pulse, and the committed HI/LO.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        int cyc;
        bit overlap;
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        tick();
        start = 1'b0;
        opA   = $urandom;
        opB   = $urandom;
        check("busy_rise", 32'(busy), 32'd1);
        cyc     = 0;
        overlap = 1'b0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) overlap = 1'b1;
            if (cyc == 10) begin
                check("hold_hi", hi, m_hi);
                check("hold_lo", lo, m_lo);
            end
            if (poke && cyc == 5) begin
                start = 1'b1;
                op    = 3'd0;
                opA   = $urandom;
                opB   = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        model(o, a, b);
        check("busy_cycles", 32'(cyc), 32'd33);
        check("busy_done_overlap", 32'(overlap), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("res_hi", hi, m_hi);
        check("res_lo", lo, m_lo);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int sel;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        opA   = 32'd0;
        opB   = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset after random MTHI/MTLO
        mt(1'b1, $urandom);
        mt(1'b0, $urandom);
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Directed arithmetic
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFEB);
        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("multu_hi_const", hi, 32'h0000_0006);
        check("multu_lo_const", lo, 32'hFFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd100, 32'd7, 1'b0);
        check("divu_lo_const", lo, 32'd14);
        check("divu_hi_const", hi, 32'd2);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo_const", lo, 32'h8000_0000);
        check("ovf_hi_const", hi, 32'd0);
        run_op(3'd3, 32'd5, 32'd0, 1'b0);
        check("div0_lo_const", lo, 32'hFFFF_FFFF);
        check("div0_hi_const", hi, 32'd5);
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);

        // Back-to-back MTHI/MTLO
        start = 1'b1;
        op    = 3'd4;
        opA   = 32'h1234_5678;
        tick();
        check("b2b_hi", hi, 32'h1234_5678);
        check("b2b_busy0", 32'(busy), 32'd0);
        op  = 3'd5;
        opA = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        m_hi  = 32'h1234_5678;
        m_lo  = 32'h9ABC_DEF0;
        check("b2b_lo", lo, 32'h9ABC_DEF0);
        check("b2b_hi_keep", hi, 32'h1234_5678);
        check("b2b_busy1", 32'(busy), 32'd0);
        check("b2b_done", 32'(done), 32'd0);

        // NOP opcodes change nothing
        for (int k = 6; k < 8; k++) begin
            start = 1'b1;
            op    = 3'(k);
            opA   = $urandom;
            tick();
            start = 1'b0;
            check("nop_hi", hi, m_hi);
            check("nop_lo", lo, m_lo);
            check("nop_busy", 32'(busy), 32'd0);
        end

        // Start while busy is ignored
        run_op(3'd0, 32'd1234, 32'hFFFF_FF00, 1'b1);

        // Reset during RUN aborts a MULTU
        mt(1'b1, 32'hAAAA_AAAA);
        mt(1'b0, 32'hAAAA_AAAA);
        start = 1'b1;
        op    = 3'd1;
        opA   = 32'hDEAD_BEEF;
        opB   = 32'h0BAD_F00D;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        check("abort_done_later", 32'(done), 32'd0);
        run_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);

        // Randomized operations with biased corners
        for (int n = 0; n < 24; n++) begin
            ro  = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(1, 15));
                3: begin
                    ra = 32'($urandom_range(0, 1000));
                    rb = 32'hFFFF_FFFF;
                end
                4: rb = 32'h8000_0000;
                default: ;
            endcase
            run_op(ro, ra, rb, (n % 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file and consumes its two read ports (regSource -> opA, regTarget -> opB).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises busy so the single-cycle core can stall any MFHI/MFLO or new mult/div until the result has been committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe, sampled on the rising edge of clk.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are NOP.
- opA  input  32  rs value; multiplicand, dividend, or MTHI/MTLO data.
- opB  input  32  rt value; multiplier or divisor.
- hi  output  32  HI register.
- lo  output  32  LO register.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO are committed by a mult/div.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - hi=0, lo=0, busy=0, done=0, state=IDLE.
  - Reset overrides start.
  - Reset in RUN or FIX aborts the operation; no partial result is written.
- States are IDLE, RUN and FIX.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch |opA|/|opB| for signed ops (raw values for unsigned ops), latch the result sign flags, clear the accumulator and the iteration counter, go to RUN.
  - start=1 with MTHI: hi<=opA at that edge. MTLO: lo<=opA at that edge. busy and done stay 0.
  - NOP or start=0: no change.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
  - The counter increments 0..ITER-1; after ITER edges the state goes to FIX.
- FIX: one cycle.
  - Apply sign correction.
  - Write hi/lo at the edge leaving FIX, then go to IDLE.
  - done=1 for exactly the cycle following that edge.
- busy = (state != IDLE); it is a registered state decode.
- Latency: start accepted at edge E0; busy is high from E0 to E33; hi/lo are updated at E33. busy is 1 for 33 cycles.
- start while busy is ignored entirely: no queueing, and inputs are not re-sampled. The core must hold off.
- opA/opB may change after E0 without effect.
- Multiply results:
  - {hi,lo} = 64-bit product.
  - MULT is two's-complement signed: negate the unsigned magnitude product if sign(A) xor sign(B).
  - MULTU is unsigned.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed DIV truncates toward zero.
  - Quotient is negative iff sign(A) xor sign(B); remainder takes the sign of the dividend.
- Divide by zero (opB=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=opA as latched (the original signed value). Still takes the full 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, with no exception.
- Magnitude of 0x80000000 is handled as unsigned 2^31; the internal datapath is 33 bits where needed.
- hi/lo change only at reset, at MTHI/MTLO in IDLE, or at FIX exit. They are stable and readable at all other times, including during RUN, when they hold the old values.
- done and busy are never high in the same cycle.

Test Plan:
- Reset: apply rst for 2 cycles after random MTHI/MTLO -> hi=0, lo=0, busy=0, done=0.
- MULT, opA=0xFFFFFFFD (-3), opB=7 -> busy high exactly 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses 1 cycle. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV, opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> each updates the next edge, busy stays 0. A second MULT start issued while busy, with different operands -> ignored; the result matches the first op only.
- rst asserted at cycle 10 of a MULTU with prior hi=lo=0xAAAA_AAAA -> hi=lo=0 the next cycle, busy=0, no done pulse. A new start then completes correctly.
